desconcatena_serial: RTL and testbench

DESCONCATENA_SERIAL -- requirements
Module: desconcatena_serial

---
 rtl/desconcatena_serial_pkg.sv | 9 +
 rtl/desconcatena_serial_contador_bits.sv | 17 +
 rtl/desconcatena_serial.sv | 56 +++++
 tb/tb_desconcatena_serial.sv | 136 +++++++++++++
 4 files changed

// File: rtl/desconcatena_serial_pkg.sv
// desconcatena_serial_pkg: state encoding and default width shared by the serializer and its counter.
package desconcatena_serial_pkg;
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DESLOCA = 2'd1,
    FIM     = 2'd2
  } estado_t;
  localparam int LARGURA_PADRAO = 12;
endpackage

// File: rtl/desconcatena_serial_contador_bits.sv
// contador_bits: bit counter with synchronous clear and increment, async reset.
module contador_bits #(
  parameter int W = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Limpa,
  input  logic         Incrementa,
  output logic [W-1:0] Contagem
);
  logic [W-1:0] cont_d, cont_q;
  always_comb cont_d = Limpa ? '0 : Incrementa ? cont_q + W'(1) : cont_q;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) cont_q <= '0;
    else cont_q <= cont_d;
  assign Contagem = cont_q;
endmodule

// File: rtl/desconcatena_serial.sv
// desconcatena_serial: parallel-to-serial shifter with valid/accept handshake and done pulse.
module desconcatena_serial
  import desconcatena_serial_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int MSB_PRIMEIRO = 1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [LARGURA-1:0] Entrada,
  input  logic               Carrega,
  output logic               Pronto,
  output logic               BitSaida,
  output logic               BitValido,
  input  logic               BitAceito,
  output logic               Ultimo,
  output logic               Ocupado,
  output logic               Concluido
);
  localparam int LW = $clog2(LARGURA + 1);
  estado_t            estado_d, estado_q;
  logic [LARGURA-1:0] reg_d, reg_q;
  logic [LW-1:0]      contagem;
  logic               carga, consome;
  assign carga   = Carrega && estado_q == OCIOSO;
  assign consome = BitAceito && estado_q == DESLOCA;
  assign Ultimo  = estado_q == DESLOCA && contagem == LW'(LARGURA - 1);
  always_comb begin
    estado_d = estado_q == OCIOSO  ? (Carrega ? DESLOCA : OCIOSO) :
               estado_q == DESLOCA ? ((consome && Ultimo) ? FIM : DESLOCA) : OCIOSO;
    // shifting toward the output end leaves zeros behind, so the register is empty once idle
    reg_d    = carga   ? Entrada :
               consome ? (MSB_PRIMEIRO != 0 ? {reg_q[LARGURA-2:0], 1'b0} : {1'b0, reg_q[LARGURA-1:1]}) :
               reg_q;
  end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      estado_q <= OCIOSO;
      reg_q    <= '0;
    end else begin
      estado_q <= estado_d;
      reg_q    <= reg_d;
    end
  contador_bits #(.W(LW)) u_contador (
    .Clock     (Clock),
    .Reset     (Reset),
    .Limpa     (carga),
    .Incrementa(consome),
    .Contagem  (contagem)
  );
  assign Pronto    = estado_q == OCIOSO;
  assign BitValido = estado_q == DESLOCA;
  assign Ocupado   = estado_q != OCIOSO;
  assign Concluido = estado_q == FIM;
  assign BitSaida  = MSB_PRIMEIRO != 0 ? reg_q[LARGURA-1] : reg_q[0];
endmodule

// File: tb/tb_desconcatena_serial.sv
// tb_desconcatena_serial: MSB-first and LSB-first instances driven in lockstep against a word-level model.
module tb_desconcatena_serial;
  logic        Clock = 1'b0;
  logic        Reset, Carrega, BitAceito;
  logic [11:0] Entrada;
  logic        pm, bm, vm, um, om, cm;
  logic        pl, bl, vl, ul, ol, cl;
  int          errors = 0, checks = 0;
  bit          busy, done;
  logic [11:0] word, got_m, got_l;
  int          k, ncons, n;

  always #5 Clock = ~Clock;

  desconcatena_serial #(.LARGURA(12), .MSB_PRIMEIRO(1)) dut_m (
    .Clock(Clock), .Reset(Reset), .Entrada(Entrada), .Carrega(Carrega), .Pronto(pm),
    .BitSaida(bm), .BitValido(vm), .BitAceito(BitAceito), .Ultimo(um), .Ocupado(om), .Concluido(cm)
  );
  desconcatena_serial #(.LARGURA(12), .MSB_PRIMEIRO(0)) dut_l (
    .Clock(Clock), .Reset(Reset), .Entrada(Entrada), .Carrega(Carrega), .Pronto(pl),
    .BitSaida(bl), .BitValido(vl), .BitAceito(BitAceito), .Ultimo(ul), .Ocupado(ol), .Concluido(cl)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs();
    logic eb_m, eb_l;
    eb_m = busy ? word[11-k] : 1'b0;
    eb_l = busy ? word[k] : 1'b0;
    chk("Pronto_m", 12'(pm), 12'(!busy && !done));
    chk("Pronto_l", 12'(pl), 12'(!busy && !done));
    chk("BitValido_m", 12'(vm), 12'(busy));
    chk("BitValido_l", 12'(vl), 12'(busy));
    chk("BitSaida_m", 12'(bm), 12'(eb_m));
    chk("BitSaida_l", 12'(bl), 12'(eb_l));
    chk("Ultimo_m", 12'(um), 12'(busy && k == 11));
    chk("Ultimo_l", 12'(ul), 12'(busy && k == 11));
    chk("Ocupado_m", 12'(om), 12'(busy || done));
    chk("Ocupado_l", 12'(ol), 12'(busy || done));
    chk("Concluido_m", 12'(cm), 12'(done));
    chk("Concluido_l", 12'(cl), 12'(done));
  endtask

  task automatic step(input logic c, input logic a);
    Carrega = c;
    BitAceito = a;
    check_outs();
    if (busy && a) begin
      got_m = {got_m[10:0], bm};
      got_l = {bl, got_l[11:1]};
      ncons++;
    end
    @(posedge Clock);
    if (done) done = 0;
    else if (busy) begin
      if (a) begin
        k++;
        if (k == 12) begin
          busy = 0;
          done = 1;
          chk("word_m", got_m, word);
          chk("word_l", got_l, word);
          chk("consumptions", 12'(ncons), 12'd12);
        end
      end
    end else if (c) begin
      busy = 1;
      word = Entrada;
      k = 0;
      ncons = 0;
    end
    #1;
  endtask

  task automatic mid_reset();
    #2 Reset = 1;
    busy = 0;
    done = 0;
    #1 check_outs();
    @(posedge Clock);
    #1 check_outs();
    Reset = 0;
  endtask

  initial begin
    Reset = 1; Carrega = 0; BitAceito = 0; Entrada = '0;
    busy = 0; done = 0; k = 0; ncons = 0; word = '0; got_m = '0; got_l = '0;
    #1 check_outs();
    @(posedge Clock);
    #1 Reset = 0;
    Entrada = 12'hA5C;
    step(1, 1);
    repeat (14) step(0, 1);
    Entrada = 12'h001;
    step(1, 1);
    repeat (14) step(0, 1);
    Entrada = 12'hFFF;
    step(1, 1);
    for (int i = 0; i < 60; i++) step(0, (i % 4 == 0) || (i % 4 == 3));
    step(1, 1);
    repeat (4) step(0, 1);
    Entrada = 12'h000;
    step(1, 1);
    repeat (10) step(0, 1);
    Entrada = 12'hFFF;
    step(1, 1);
    repeat (6) step(0, 1);
    mid_reset();
    Entrada = 12'h800;
    step(1, 1);
    repeat (14) step(0, 1);
    Entrada = 12'h000;
    step(1, 1);
    n = 0;
    do begin
      n++;
      step(0, 1);
    end while (!pm && n < 30);
    chk("period", 12'(n + 1), 12'd14);
    step(1, 1);
    repeat (30) step(1, 1);
    for (int i = 0; i < 600; i++) begin
      Entrada = 12'($urandom);
      if ($urandom_range(0, 99) == 0) mid_reset();
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
